// File: rtl/data_recorder.sv
// Eight-entry measurement recorder: save snapshots Dis into a circular buffer,
// recall steps newest-to-oldest in VIEW, with an idle timeout back to LIVE.
module data_recorder #(
  parameter int unsigned TIMEOUT = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Dis,
  input  logic        save,
  input  logic        recall,
  input  logic        clear,
  output logic [15:0] save_data,
  output logic        ctrl,
  output logic [3:0]  count,
  output logic [2:0]  idx,
  output logic        full
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {LIVE = 1'b0, VIEW = 1'b1} state_t;

  state_t        state_q;
  logic [15:0]   mem [8];
  logic [2:0]    wr_ptr_q, rd_ptr_q;
  logic [TW-1:0] timer_q;
  logic          save_q, recall_q;
  logic [15:0]   save_data_q;
  logic [3:0]    count_q;
  logic [2:0]    idx_q;
  logic          full_q;
  logic          save_ev, recall_ev, wr_en;

  assign save_ev   = save & ~save_q;
  assign recall_ev = recall & ~recall_q;
  assign wr_en     = ~clear & (state_q == LIVE) & save_ev;

  // Buffer RAM carries no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= Dis;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LIVE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      timer_q     <= '0;
      save_q      <= 1'b0;
      recall_q    <= 1'b0;
      save_data_q <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      full_q      <= 1'b0;
    end else begin
      save_q   <= save;
      recall_q <= recall;
      if (clear) begin
        state_q     <= LIVE;
        count_q     <= '0;
        full_q      <= 1'b0;
        wr_ptr_q    <= '0;
        idx_q       <= '0;
        save_data_q <= '0;
        timer_q     <= '0;
      end else begin
        case (state_q)
          LIVE: begin
            if (save_ev) begin
              wr_ptr_q <= wr_ptr_q + 3'd1;
              if (count_q != 4'd8) begin
                count_q <= count_q + 4'd1;
                full_q  <= (count_q == 4'd7);
              end
            end else if (recall_ev && count_q != 4'd0) begin
              state_q     <= VIEW;
              rd_ptr_q    <= wr_ptr_q - 3'd1;
              idx_q       <= '0;
              save_data_q <= mem[wr_ptr_q - 3'd1];
              timer_q     <= '0;
            end
          end
          VIEW: begin
            if (save_ev) begin
              state_q     <= LIVE;
              save_data_q <= '0;
              idx_q       <= '0;
            end else if (recall_ev) begin
              timer_q <= '0;
              if ({1'b0, idx_q} < count_q - 4'd1) begin
                rd_ptr_q    <= rd_ptr_q - 3'd1;
                idx_q       <= idx_q + 3'd1;
                save_data_q <= mem[rd_ptr_q - 3'd1];
              end else begin
                state_q     <= LIVE;
                save_data_q <= '0;
                idx_q       <= '0;
              end
            end else if (timer_q == TMO_LAST) begin
              state_q     <= LIVE;
              save_data_q <= '0;
              idx_q       <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          default: state_q <= LIVE;
        endcase
      end
    end
  end

  assign ctrl      = (state_q == VIEW);
  assign save_data = save_data_q;
  assign count     = count_q;
  assign idx       = idx_q;
  assign full      = full_q;

endmodule

// File: doc/data_recorder.md
DATA_RECORDER -- requirements
Module: data_recorder

Interface
REQ-001 Parameter: TIMEOUT, 50_000_000, idle clock cycles in VIEW before automatic return to LIVE.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: Dis  input  16  live measurement value (4 BCD digits), sampled on save.
REQ-005 Port: save  input  1  debounced, clk-synchronous save button level.
REQ-006 Port: recall  input  1  debounced, clk-synchronous recall button level.
REQ-007 Port: clear  input  1  synchronous clear request (level).
REQ-008 Port: save_data  output  16  recalled record, registered.
REQ-009 Port: ctrl  output  1  registered; 1 = VIEW (display shows save_data), 0 = LIVE (display shows Dis).
REQ-010 Port: count  output  4  number of valid records, 0..8, registered.
REQ-011 Port: idx  output  3  age of the record on save_data (0 = newest), registered.
REQ-012 Port: full  output  1  registered; 1 when count == 8.

Function
REQ-013 Storage: 8 x 16-bit circular buffer, 3-bit write pointer wr_ptr, 3-bit read pointer rd_ptr.
REQ-014 Edge detect: save_ev = save & ~save_q, recall_ev = recall & ~recall_q; save_q/recall_q are the previous-cycle samples; a held level yields exactly one event.
REQ-015 Two states: LIVE (ctrl=0) and VIEW (ctrl=1).
REQ-016 Priority each cycle: clear > save_ev > recall_ev > timeout.
REQ-017 clear (any state): count<=0, wr_ptr<=0, idx<=0, save_data<=0, state<=LIVE; buffer contents are don't-care.
REQ-018 LIVE + save_ev: mem[wr_ptr]<=Dis at that edge; wr_ptr<=wr_ptr+1 mod 8; count<=min(count+1,8).
REQ-019 Save when full: overwrites the oldest record; count stays 8.
REQ-020 LIVE + recall_ev with count==0: ignored; state stays LIVE.
REQ-021 LIVE + recall_ev with count>0: state<=VIEW, rd_ptr<=wr_ptr-1 mod 8, idx<=0, save_data<=newest record; ctrl=1 and save_data valid on the same edge.
REQ-022 VIEW + recall_ev with idx<count-1: rd_ptr<=rd_ptr-1 mod 8, idx<=idx+1, save_data<=mem[rd_ptr-1].
REQ-023 VIEW + recall_ev with idx==count-1 (oldest shown): state<=LIVE, save_data<=0, idx<=0.
REQ-024 VIEW + save_ev: state<=LIVE, save_data<=0, idx<=0; no record written.
REQ-025 Idle timer: cleared on entry to VIEW and on every recall_ev; increments each VIEW cycle; when it reaches TIMEOUT-1: state<=LIVE, save_data<=0, idx<=0.
REQ-026 In LIVE: save_data==0 and idx==0 at all times.
REQ-027 full == (count==8) at all times; count never exceeds 8 and never wraps.
REQ-028 Dis is not used except on a LIVE save_ev edge.

Reset
REQ-029 rst_n low asynchronously forces: state LIVE, ctrl=0, save_data=0, count=0, idx=0, full=0, wr_ptr=0, rd_ptr=0, timer=0, save_q=0, recall_q=0.
REQ-030 Reset mid-VIEW or mid-press: after release, a still-high save or recall level generates one event on the first rising clock edge.
REQ-031 Buffer RAM is not reset; count=0 makes its contents unobservable.

Verification (bench uses TIMEOUT=16)
REQ-032 Reset, then save Dis=0x0123, 0x0456, 0x0789 -> count=3, full=0, ctrl=0, save_data=0.
REQ-033 Recall x4 after REQ-032 -> save_data 0x0789 (idx0), 0x0456 (idx1), 0x0123 (idx2), then ctrl=0, save_data=0.
REQ-034 Save 10 values 0x0001..0x000A, recall -> count=8, full=1, newest 0x000A, eighth recall shows 0x0003, ninth returns to LIVE.
REQ-035 Enter VIEW, idle 16 cycles -> ctrl=0 on the 16th VIEW cycle; recall on cycle 10 restarts the count.
REQ-036 save, recall, clear asserted together in VIEW -> LIVE, count=0, no write; held save -> exactly one record.
REQ-037 rst_n low mid-VIEW with count=5 -> outputs zero immediately, without waiting for a clk edge; recall with count=0 stays in LIVE.
